// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Outputs are decoded from the state so that every state drives them the same way.
package pll_seq_pkg;

    localparam int unsigned PLL_SEQ_CNT_W = 8;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_seq_state_t;

    typedef struct packed {
        logic pll_rst;
        logic sys_rst_n;
        logic ready;
        logic fault;
    } pll_seq_out_t;

    function automatic pll_seq_out_t pll_seq_outs(input pll_seq_state_t st);
        pll_seq_out_t o;
        o = '0;
        case (st)
            RESET: begin
                o.pll_rst = 1'b1;
            end
            RUN: begin
                o.sys_rst_n = 1'b1;
                o.ready     = 1'b1;
            end
            FAULT: begin
                o.pll_rst = 1'b1;
                o.fault   = 1'b1;
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

    function automatic logic [PLL_SEQ_CNT_W-1:0] sat_inc(input logic [PLL_SEQ_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-stage synchronizer with asynchronous active-low reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up controller: holds the PLL in reset, waits for lock with a timeout and bounded
// retries, and releases the downstream reset once lock has been stable long enough.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES     = 1000,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 10_000,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic                     CLKI,
    input  logic                     Reset_n,
    input  logic                     LOCK,
    output logic                     PLL_RST,
    output logic                     SYS_Reset_n,
    output logic                     Ready,
    output logic                     Fault,
    output logic [PLL_SEQ_CNT_W-1:0] Retry_count,
    output logic [PLL_SEQ_CNT_W-1:0] Lock_loss_count
);

    localparam int unsigned MaxHoldWait = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                          RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MaxCycles   = (MaxHoldWait > LOCK_STABLE_CYCLES) ?
                                          MaxHoldWait : LOCK_STABLE_CYCLES;
    localparam int unsigned CntW        = $clog2(MaxCycles) + 1;

    typedef logic [CntW-1:0] cnt_t;
    typedef logic [PLL_SEQ_CNT_W-1:0] count_t;

    // Counter reloads are N-1 so that a state lasts exactly N cycles.
    localparam cnt_t   HoldLoad    = cnt_t'(RST_HOLD_CYCLES - 1);
    localparam cnt_t   TimeoutLoad = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
    localparam cnt_t   StableLoad  = cnt_t'(LOCK_STABLE_CYCLES - 1);
    localparam count_t RetryLimit  = count_t'(MAX_RETRIES);

    logic           lock_s;
    pll_seq_state_t state_q;
    cnt_t           cnt_q;
    count_t         retry_q;
    count_t         loss_q;
    pll_seq_out_t   out_q;

    sync_2ff u_lock_sync (
        .clk_i  (CLKI),
        .rst_ni (Reset_n),
        .d_i    (LOCK),
        .q_o    (lock_s)
    );

    always_ff @(posedge CLKI or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= RESET;
            cnt_q   <= HoldLoad;
            retry_q <= '0;
            loss_q  <= '0;
            out_q   <= pll_seq_outs(RESET);
        end else begin
            unique case (state_q)
                RESET: begin
                    if (cnt_q == '0) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= TimeoutLoad;
                        out_q   <= pll_seq_outs(WAIT_LOCK);
                    end else begin
                        cnt_q <= cnt_q - cnt_t'(1);
                    end
                end
                WAIT_LOCK: begin
                    // Lock takes priority over a timeout landing in the same cycle.
                    if (lock_s) begin
                        state_q <= STABLE;
                        cnt_q   <= StableLoad;
                        out_q   <= pll_seq_outs(STABLE);
                    end else if (cnt_q == '0) begin
                        if (retry_q == RetryLimit) begin
                            state_q <= FAULT;
                            cnt_q   <= '0;
                            out_q   <= pll_seq_outs(FAULT);
                        end else begin
                            state_q <= RESET;
                            cnt_q   <= HoldLoad;
                            retry_q <= retry_q + 1'b1;
                            out_q   <= pll_seq_outs(RESET);
                        end
                    end else begin
                        cnt_q <= cnt_q - cnt_t'(1);
                    end
                end
                STABLE: begin
                    // A dropout restarts the lock wait without consuming a retry.
                    if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= TimeoutLoad;
                        out_q   <= pll_seq_outs(WAIT_LOCK);
                    end else if (cnt_q == '0) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        retry_q <= '0;
                        out_q   <= pll_seq_outs(RUN);
                    end else begin
                        cnt_q <= cnt_q - cnt_t'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_q <= RESET;
                        cnt_q   <= HoldLoad;
                        loss_q  <= sat_inc(loss_q);
                        out_q   <= pll_seq_outs(RESET);
                    end
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= RESET;
                    cnt_q   <= HoldLoad;
                    out_q   <= pll_seq_outs(RESET);
                end
            endcase
        end
    end

    assign PLL_RST         = out_q.pll_rst;
    assign SYS_Reset_n     = out_q.sys_rst_n;
    assign Ready           = out_q.ready;
    assign Fault           = out_q.fault;
    assign Retry_count     = retry_q;
    assign Lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scenario bench for pll_reset_sequencer: expectations are queued as stimulus is applied and
// popped when the corresponding output event is observed.
module tb_pll_reset_sequencer;

    // Output word layout: {12'd0, PLL_RST, SYS_Reset_n, Ready, Fault, Retry_count, Lock_loss_count}
    localparam logic [31:0] RstWord  = 32'h0008_0000;
    localparam logic [31:0] RunWord  = 32'h0006_0000;
    localparam logic [31:0] WaitWord = 32'h0000_0000;

    logic       CLKI    = 1'b0;
    logic       Reset_n = 1'b0;
    logic       LOCK    = 1'b0;
    logic       PLL_RST;
    logic       SYS_Reset_n;
    logic       Ready;
    logic       Fault;
    logic [7:0] Retry_count;
    logic [7:0] Lock_loss_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2)
    ) dut (
        .CLKI            (CLKI),
        .Reset_n         (Reset_n),
        .LOCK            (LOCK),
        .PLL_RST         (PLL_RST),
        .SYS_Reset_n     (SYS_Reset_n),
        .Ready           (Ready),
        .Fault           (Fault),
        .Retry_count     (Retry_count),
        .Lock_loss_count (Lock_loss_count)
    );

    always #5 CLKI = ~CLKI;

    function automatic logic [31:0] outs_word();
        return {12'd0, PLL_RST, SYS_Reset_n, Ready, Fault, Retry_count, Lock_loss_count};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLKI);
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        sb.push_back('{tag: tag, val: val});
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) e = '{tag: "scoreboard_empty", val: 32'hDEAD_BEEF};
        else e = sb.pop_front();
    endtask

    // Negedges until SYS_Reset_n reaches lvl; -1 when the budget runs out.
    task automatic wait_sys(input logic lvl, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget && n < 0; i++) begin
            tick();
            if (SYS_Reset_n === lvl) n = i;
        end
    endtask

    // Negedges until PLL_RST is seen going 0 -> 1; -1 when the budget runs out.
    task automatic wait_pll_rise(input int budget, output int n);
        logic prev;
        prev = PLL_RST;
        n = -1;
        for (int i = 1; i <= budget && n < 0; i++) begin
            tick();
            if (PLL_RST === 1'b1 && prev === 1'b0) n = i;
            prev = PLL_RST;
        end
    endtask

    // Samples, starting at the current negedge, for which PLL_RST stays high.
    task automatic measure_pll_rst(input int budget, output int n);
        n = 0;
        while (PLL_RST === 1'b1 && n < budget) begin
            n++;
            tick();
        end
    endtask

    task automatic apply_reset();
        Reset_n = 1'b0;
        LOCK    = 1'b0;
        tick(2);
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] obs;
        Reset_n = 1'b0;
        LOCK    = 1'b0;
        push_exp("reset_outputs", RstWord);
        tick(2);
        obs = outs_word();
        pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic test_clean_bringup();
        exp_t e;
        logic [31:0] obs;
        int n;
        apply_reset();
        push_exp("bringup_pll_rst_len", 32'd4);
        measure_pll_rst(50, n);
        obs = n; pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got %0d want %0d", e.tag, obs, e.val);
        end
        tick(5);
        LOCK = 1'b1;
        push_exp("bringup_sys_latency", 32'd11);
        push_exp("bringup_run_word", RunWord);
        wait_sys(1'b1, 40, n);
        obs = n; pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got %0d want %0d", e.tag, $signed(obs), e.val);
        end
        obs = outs_word(); pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic test_exhausted_retries();
        exp_t e;
        logic [31:0] obs;
        logic prev;
        int fault_cyc;
        apply_reset();
        push_exp("retry1_word", 32'h0008_0100);
        push_exp("retry2_word", 32'h0008_0200);
        push_exp("fault_entry_word", 32'h0009_0200);
        push_exp("fault_entry_cycle", 32'd72);
        prev = PLL_RST;
        fault_cyc = -1;
        for (int cyc = 1; cyc <= 200 && fault_cyc < 0; cyc++) begin
            tick();
            if (PLL_RST === 1'b1 && prev === 1'b0) begin
                obs = outs_word(); pop_exp(e); checks++;
                if (obs !== e.val) begin
                    failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.tag, obs, e.val);
                end
                if (Fault === 1'b1) fault_cyc = cyc;
            end
            prev = PLL_RST;
        end
        obs = fault_cyc; pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got %0d want %0d", e.tag, $signed(obs), e.val);
        end
        push_exp("fault_held_1000", 32'h0009_0200);
        tick(1000);
        obs = outs_word(); pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.tag, obs, e.val);
        end
        push_exp("fault_cleared_by_reset", RstWord);
        Reset_n = 1'b0;
        #1;
        obs = outs_word(); pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.tag, obs, e.val);
        end
        tick();
    endtask

    task automatic test_stable_glitch();
        exp_t e;
        logic [31:0] obs;
        int n;
        apply_reset();
        measure_pll_rst(50, n);
        LOCK = 1'b1;
        tick(7);
        LOCK = 1'b0;
        tick(3);
        push_exp("glitch_back_in_wait", WaitWord);
        obs = outs_word(); pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.tag, obs, e.val);
        end
        LOCK = 1'b1;
        push_exp("glitch_fresh_stable_latency", 32'd11);
        push_exp("glitch_run_word", RunWord);
        wait_sys(1'b1, 40, n);
        obs = n; pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got %0d want %0d", e.tag, $signed(obs), e.val);
        end
        obs = outs_word(); pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic test_lock_loss_run();
        exp_t e;
        logic [31:0] obs;
        int n;
        tick(2);
        LOCK = 1'b0;
        push_exp("loss_sys_latency", 32'd3);
        push_exp("loss_word", 32'h0008_0001);
        push_exp("loss_pll_rst_len", 32'd4);
        wait_sys(1'b0, 20, n);
        obs = n; pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got %0d want %0d", e.tag, $signed(obs), e.val);
        end
        obs = outs_word(); pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.tag, obs, e.val);
        end
        measure_pll_rst(50, n);
        obs = n; pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got %0d want %0d", e.tag, obs, e.val);
        end
        LOCK = 1'b1;
        push_exp("loss_recover_latency", 32'd11);
        push_exp("loss_recover_word", 32'h0006_0001);
        wait_sys(1'b1, 40, n);
        obs = n; pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got %0d want %0d", e.tag, $signed(obs), e.val);
        end
        obs = outs_word(); pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic test_second_attempt();
        exp_t e;
        logic [31:0] obs;
        int n;
        apply_reset();
        push_exp("attempt2_start_cycle", 32'd24);
        push_exp("attempt2_start_word", 32'h0008_0100);
        push_exp("attempt2_wait_word", 32'h0000_0100);
        wait_pll_rise(100, n);
        obs = n; pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got %0d want %0d", e.tag, $signed(obs), e.val);
        end
        obs = outs_word(); pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.tag, obs, e.val);
        end
        measure_pll_rst(50, n);
        obs = outs_word(); pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.tag, obs, e.val);
        end
        LOCK = 1'b1;
        push_exp("attempt2_sys_latency", 32'd11);
        push_exp("attempt2_run_word", RunWord);
        wait_sys(1'b1, 40, n);
        obs = n; pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got %0d want %0d", e.tag, $signed(obs), e.val);
        end
        obs = outs_word(); pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic test_midop_reset_and_saturation();
        exp_t e;
        logic [31:0] obs;
        int n;
        apply_reset();
        measure_pll_rst(50, n);
        LOCK = 1'b1;
        push_exp("midop_first_run_latency", 32'd11);
        wait_sys(1'b1, 40, n);
        obs = n; pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got %0d want %0d", e.tag, $signed(obs), e.val);
        end
        LOCK = 1'b0;
        push_exp("midop_retry_rise_cycle", 32'd24);
        push_exp("midop_before_reset_word", 32'h0000_0101);
        push_exp("midop_async_reset_word", RstWord);
        wait_sys(1'b0, 20, n);
        wait_pll_rise(60, n);
        obs = n; pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got %0d want %0d", e.tag, $signed(obs), e.val);
        end
        measure_pll_rst(50, n);
        tick(9);
        obs = outs_word(); pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.tag, obs, e.val);
        end
        #2 Reset_n = 1'b0;
        #1;
        obs = outs_word(); pop_exp(e); checks++;
        if (obs !== e.val) begin
            failures++; $display("FAIL %s: got 0x%0h want 0x%0h", e.tag, obs, e.val);
        end
        tick();
        Reset_n = 1'b1;
        measure_pll_rst(50, n);
        LOCK = 1'b1;
        wait_sys(1'b1, 40, n);
        for (int k = 1; k <= 256; k++) begin
            LOCK = 1'b0;
            push_exp("sat_loss_latency", 32'd3);
            push_exp("sat_loss_count", (k > 255) ? 32'd255 : 32'(k));
            wait_sys(1'b0, 20, n);
            obs = n; pop_exp(e); checks++;
            if (obs !== e.val) begin
                failures++; $display("FAIL %s[%0d]: got %0d want %0d", e.tag, k, $signed(obs), e.val);
            end
            obs = {24'd0, Lock_loss_count}; pop_exp(e); checks++;
            if (obs !== e.val) begin
                failures++; $display("FAIL %s[%0d]: got %0d want %0d", e.tag, k, obs, e.val);
            end
            LOCK = 1'b1;
            wait_sys(1'b1, 40, n);
        end
    endtask

    initial begin
        test_reset();
        test_clean_bringup();
        test_exhausted_retries();
        test_stable_glitch();
        test_lock_loss_run();
        test_second_attempt();
        test_midop_reset_and_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
